audio_tone_sequencer: RTL and testbench



---
 rtl/audio_tone_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_audio_tone_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_sequencer.sv
// rtl/audio_tone_sequencer.sv - host-queued note sequencer driving the AudioDAC register port
//
// Purpose: the host stages freq/vol and pushes notes {freq, vol, dur} into a FIFO.
// The sequencer pops each note, writes Volume/Freq/Mode to the DAC, holds it for
// dur millisecond ticks, and writes stream mode back once the queue drains.
//
// Optional feature macro: AUDIO_SEQ_LOOP_EN (CTRL bit3 LOOP re-queues each played note).
//
// Ports:
//   Clk, Resetn          clock, synchronous active-low reset
//   Addr, DataWr, DataRd host register bus (DataRd combinational from Addr)
//   En, Rd, Wr           host select / read strobe / write strobe (write on En&Wr)
//   DacAddr, DacDataWr   AudioDAC register address / write data
//   DacEn, DacWr         AudioDAC select / write strobe, one cycle per write
module audio_tone_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 50000
) (
  input  logic        Clk,
  input  logic        Resetn,
  input  logic [3:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic [3:0]  DacAddr,
  output logic [15:0] DacDataWr,
  output logic        DacEn,
  output logic        DacWr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [4:0]    DEPTH   = 5'(FIFO_DEPTH);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WR_VOL, WR_FREQ, WR_MODE, PLAY, RESTORE
  } stateT;

  stateT state, nextState;

  logic        run;
  logic        overflow;
  logic [15:0] stagedFreq;
  logic [7:0]  stagedVol;

  logic [35:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [4:0]    count;

  logic [15:0]   noteFreq;
  logic [7:0]    noteVol;
  logic [11:0]   noteDur;
  logic [PW-1:0] prescaler;
  logic [11:0]   durCnt;

  // Reads have no side effects, so the read strobe carries no information.
  logic unusedRd;
  assign unusedRd = Rd;

  logic hostWr, ctrlWr, flush, clrOvf, hostPush;
  assign hostWr   = En & Wr;
  assign ctrlWr   = hostWr && (Addr == 4'd0);
  assign flush    = ctrlWr && DataWr[1];
  assign clrOvf   = ctrlWr && DataWr[2];
  assign hostPush = hostWr && (Addr == 4'd4);

  logic empty, full, popOk;
  assign empty = (count == 5'd0);
  assign full  = (count == DEPTH);
  assign popOk = (state == LOAD) && !empty;

  logic        hostBlocked, hostPushOk, fifoPush;
  logic [35:0] pushData;

`ifdef AUDIO_SEQ_LOOP_EN
  logic loopEn;
  logic loopPush;
  // The loop re-push owns the write port in LOAD, so a host push there is lost.
  assign loopPush    = popOk && loopEn;
  assign hostBlocked = full || loopPush;
  assign hostPushOk  = hostPush && !hostBlocked && !flush;
  assign fifoPush    = (hostPushOk || loopPush) && !flush;
  assign pushData    = loopPush ? mem[rdPtr] : {stagedFreq, stagedVol, DataWr[11:0]};
`else
  assign hostBlocked = full;
  assign hostPushOk  = hostPush && !hostBlocked && !flush;
  assign fifoPush    = hostPushOk;
  assign pushData    = {stagedFreq, stagedVol, DataWr[11:0]};
`endif

  // A push in this cycle lands before the next state's first cycle, so it
  // counts as a pending note even though count has not caught up yet.
  logic haveNext;
  assign haveNext = !empty || hostPushOk;

  logic tick, playDone;
  assign tick     = (prescaler == PRE_MAX);
  assign playDone = (durCnt == 12'd0) || (tick && (durCnt == 12'd1));

  // Host registers
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      run        <= 1'b0;
      overflow   <= 1'b0;
      stagedFreq <= 16'h0000;
      stagedVol  <= 8'h00;
`ifdef AUDIO_SEQ_LOOP_EN
      loopEn     <= 1'b0;
`endif
    end else begin
      if (ctrlWr) begin
        run <= DataWr[0];
`ifdef AUDIO_SEQ_LOOP_EN
        loopEn <= DataWr[3];
`endif
      end
      if (hostWr && (Addr == 4'd2)) stagedFreq <= DataWr;
      if (hostWr && (Addr == 4'd3)) stagedVol  <= DataWr[7:0];
      // A new overflow in the same cycle as a clear is kept.
      if (hostPush && hostBlocked) overflow <= 1'b1;
      else if (clrOvf)             overflow <= 1'b0;
    end
  end

  // FIFO storage (not reset; validity is tracked by count)
  always_ff @(posedge Clk) begin
    if (fifoPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge Clk) begin
    if (!Resetn || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= 5'd0;
    end else begin
      if (fifoPush) wrPtr <= wrPtr + AW'(1);
      if (popOk)    rdPtr <= rdPtr + AW'(1);
      case ({fifoPush, popOk})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Note register, prescaler and duration counter
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      noteFreq  <= 16'h0000;
      noteVol   <= 8'h00;
      noteDur   <= 12'h000;
      prescaler <= '0;
      durCnt    <= 12'h000;
    end else begin
      if (popOk) {noteFreq, noteVol, noteDur} <= mem[rdPtr];
      if (state == PLAY) begin
        prescaler <= tick ? '0 : prescaler + PW'(1);
        if (tick) durCnt <= durCnt - 12'd1;
      end else begin
        // Held preloaded outside PLAY so the first PLAY cycle starts fresh.
        prescaler <= '0;
        durCnt    <= noteDur;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    DacEn     = 1'b0;
    DacWr     = 1'b0;
    DacAddr   = 4'd0;
    DacDataWr = 16'h0000;
    case (state)
      IDLE: begin
        if (run && haveNext && !flush) nextState = LOAD;
      end
      LOAD: nextState = WR_VOL;
      WR_VOL: begin
        DacEn     = 1'b1;
        DacWr     = 1'b1;
        DacAddr   = 4'd1;
        DacDataWr = {8'h00, noteVol};
        nextState = WR_FREQ;
      end
      WR_FREQ: begin
        DacEn     = 1'b1;
        DacWr     = 1'b1;
        DacAddr   = 4'd2;
        DacDataWr = noteFreq;
        nextState = WR_MODE;
      end
      WR_MODE: begin
        DacEn     = 1'b1;
        DacWr     = 1'b1;
        DacAddr   = 4'd0;
        DacDataWr = (noteFreq == 16'h0000) ? 16'h0000 : 16'h0001;
        nextState = PLAY;
      end
      PLAY: begin
        // Chaining straight into LOAD avoids a stream-mode blip between notes.
        if (playDone) nextState = (run && haveNext) ? LOAD : RESTORE;
      end
      RESTORE: begin
        DacEn     = 1'b1;
        DacWr     = 1'b1;
        DacAddr   = 4'd0;
        DacDataWr = 16'h0002;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Any DAC write already on the port this cycle still goes out.
    if (flush && (state != IDLE) && (state != RESTORE)) nextState = RESTORE;
  end

  // Host read mux
  logic [15:0] statusWord;
  assign statusWord = {(state != IDLE), overflow, full, empty, 7'h00, count};

  always_comb begin
    DataRd = 16'h0000;
    case (Addr)
`ifdef AUDIO_SEQ_LOOP_EN
      4'd0: DataRd = {12'h000, loopEn, 2'b00, run};
`else
      4'd0: DataRd = {15'h0000, run};
`endif
      4'd1: DataRd = statusWord;
      4'd2: DataRd = stagedFreq;
      4'd3: DataRd = {8'h00, stagedVol};
      default: DataRd = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// tb/tb_audio_tone_sequencer.sv - directed self-checking bench for audio_tone_sequencer
module tb_audio_tone_sequencer;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [3:0]  Addr = 4'd0;
  logic [15:0] DataWr = 16'h0000;
  logic [15:0] DataRd;
  logic        En = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [3:0]  DacAddr;
  logic [15:0] DacDataWr;
  logic        DacEn;
  logic        DacWr;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int lastWrCyc = 0;
  int idleCyc = 0;

  logic [19:0] logW [$];
  int          logC [$];

  audio_tone_sequencer #(.FIFO_DEPTH(8), .TICK_DIV(4)) dut (
    .Clk(Clk), .Resetn(Resetn), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr), .DacAddr(DacAddr), .DacDataWr(DacDataWr),
    .DacEn(DacEn), .DacWr(DacWr)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (DacEn && DacWr) begin
      logW.push_back({DacAddr, DacDataWr});
      logC.push_back(cyc);
    end
  end

  task automatic hostWrite(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; En = 1'b1; Wr = 1'b1;
    #1 lastWrCyc = cyc;
    @(negedge Clk);
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic hostRead(input logic [3:0] a, output logic [15:0] d);
    @(negedge Clk);
    Addr = a; En = 1'b1; Rd = 1'b1;
    #1 d = DataRd;
    En = 1'b0; Rd = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    Addr = 4'd1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      #1;
      if (!DataRd[15]) begin
        idleCyc = cyc;
        done = 1;
        break;
      end
    end
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL %s_idle_timeout: busy still 1, required 0 within 1000 cycles", name);
    end
  endtask

  task automatic test_reset;
    logic [15:0] r;
    bit sawDac = 0;
    Resetn = 1'b0;
    repeat (3) @(negedge Clk);
    vecs++;
    if ({DacEn, DacWr, DacAddr, DacDataWr} !== 22'h0) begin
      errs++; $display("FAIL reset_dac: got %h required 0", {DacEn, DacWr, DacAddr, DacDataWr});
    end
    Resetn = 1'b1;
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h1000) begin errs++; $display("FAIL reset_status: got %h required 1000", r); end
    hostWrite(4'd0, 16'h0001);
    hostRead(4'd0, r);
    vecs++;
    if (r !== 16'h0001) begin errs++; $display("FAIL ctrl_run_read: got %h required 0001", r); end
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (DacEn) sawDac = 1;
    end
    vecs++;
    if (sawDac) begin errs++; $display("FAIL idle_no_dac: DacEn got 1 required 0 for 100 cycles"); end
  endtask

  task automatic test_single_note;
    int p;
    logic [19:0] expv [4];
    expv = '{20'h1_0020, 20'h2_0100, 20'h0_0001, 20'h0_0002};
    hostWrite(4'd2, 16'h0100);
    hostWrite(4'd3, 16'hAB20);
    logW.delete(); logC.delete();
    hostWrite(4'd4, 16'h0003);
    p = lastWrCyc;
    waitIdle("single");
    vecs++;
    if (logW.size() != 4) begin
      errs++; $display("FAIL single_count: got %0d writes required 4", logW.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (logW[i] !== expv[i]) begin
          errs++; $display("FAIL single_write%0d: got %h required %h", i, logW[i], expv[i]);
        end
      end
      vecs++;
      if (logC[0] != p + 2 || logC[1] != p + 3 || logC[2] != p + 4) begin
        errs++; $display("FAIL single_latency: got %0d/%0d/%0d required %0d/%0d/%0d",
                         logC[0] - p, logC[1] - p, logC[2] - p, 2, 3, 4);
      end
      vecs++;
      if (logC[3] - logC[2] != 13) begin
        errs++; $display("FAIL single_play_len: got %0d required 12", logC[3] - logC[2] - 1);
      end
      vecs++;
      if (idleCyc != logC[3] + 1) begin
        errs++; $display("FAIL single_busy_drop: got %0d required %0d", idleCyc, logC[3] + 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r;
    logic [19:0] expv [7];
    expv = '{20'h1_0010, 20'h2_0200, 20'h0_0001,
             20'h1_0010, 20'h2_0000, 20'h0_0000, 20'h0_0002};
    hostWrite(4'd2, 16'h0200);
    hostWrite(4'd3, 16'h0010);
    logW.delete(); logC.delete();
    hostWrite(4'd4, 16'h0001);
    hostWrite(4'd2, 16'h0000);
    hostWrite(4'd4, 16'h0002);
    waitIdle("b2b");
    vecs++;
    if (logW.size() != 7) begin
      errs++; $display("FAIL b2b_count: got %0d writes required 7", logW.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vecs++;
        if (logW[i] !== expv[i]) begin
          errs++; $display("FAIL b2b_write%0d: got %h required %h", i, logW[i], expv[i]);
        end
      end
    end
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h1000) begin errs++; $display("FAIL b2b_status: got %h required 1000", r); end
  endtask

  task automatic test_overflow;
    logic [15:0] r;
    hostWrite(4'd0, 16'h0000);
    for (int i = 0; i < 8; i++) hostWrite(4'd4, 16'(i + 1));
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h2008) begin errs++; $display("FAIL ovf_full8: got %h required 2008", r); end
    hostWrite(4'd4, 16'h0009);
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h6008) begin errs++; $display("FAIL ovf_push9: got %h required 6008", r); end
    hostWrite(4'd0, 16'h0004);
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h2008) begin errs++; $display("FAIL ovf_clear: got %h required 2008", r); end
    hostWrite(4'd0, 16'h0002);
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h1000) begin errs++; $display("FAIL ovf_flush_idle: got %h required 1000", r); end
  endtask

  task automatic test_flush_play;
    int f;
    hostWrite(4'd0, 16'h0001);
    hostWrite(4'd2, 16'h0300);
    hostWrite(4'd3, 16'h0030);
    hostWrite(4'd4, 16'd100);
    hostWrite(4'd4, 16'd5);
    repeat (20) @(negedge Clk);
    logW.delete(); logC.delete();
    hostWrite(4'd0, 16'h0003);
    f = lastWrCyc;
    @(negedge Clk);
    Addr = 4'd1;
    #1;
    vecs++;
    if (DataRd !== 16'h1000 || cyc != f + 2) begin
      errs++; $display("FAIL flush_status: got %h at +%0d required 1000 at +2", DataRd, cyc - f);
    end
    repeat (10) @(negedge Clk);
    vecs++;
    if (logW.size() != 1) begin
      errs++; $display("FAIL flush_writes: got %0d writes required 1", logW.size());
    end else begin
      vecs++;
      if (logW[0] !== 20'h0_0002 || logC[0] != f + 1) begin
        errs++; $display("FAIL flush_restore: got %h at +%0d required 00002 at +1", logW[0], logC[0] - f);
      end
    end
  endtask

  task automatic test_run_clear;
    logic [15:0] r;
    logic [19:0] expv [4];
    expv = '{20'h1_0040, 20'h2_0400, 20'h0_0001, 20'h0_0002};
    hostWrite(4'd2, 16'h0400);
    hostWrite(4'd3, 16'h0040);
    logW.delete(); logC.delete();
    hostWrite(4'd4, 16'h0003);
    hostWrite(4'd4, 16'h0001);
    hostWrite(4'd0, 16'h0000);
    waitIdle("runclr");
    vecs++;
    if (logW.size() != 4) begin
      errs++; $display("FAIL runclr_count: got %0d writes required 4", logW.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vecs++;
        if (logW[i] !== expv[i]) begin
          errs++; $display("FAIL runclr_write%0d: got %h required %h", i, logW[i], expv[i]);
        end
      end
    end
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h0001) begin errs++; $display("FAIL runclr_retained: got %h required 0001", r); end
    hostWrite(4'd0, 16'h0002);
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    hostWrite(4'd0, 16'h0001);
    hostWrite(4'd4, 16'h0003);
    repeat (8) @(negedge Clk);
    logW.delete(); logC.delete();
    Resetn = 1'b0;
    @(negedge Clk);
    Resetn = 1'b1;
    repeat (20) @(negedge Clk);
    vecs++;
    if (logW.size() != 0) begin
      errs++; $display("FAIL rstmid_writes: got %0d writes required 0", logW.size());
    end
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h1000) begin errs++; $display("FAIL rstmid_status: got %h required 1000", r); end
    hostRead(4'd2, r);
    vecs++;
    if (r !== 16'h0000) begin errs++; $display("FAIL rstmid_freq: got %h required 0000", r); end
  endtask

  task automatic test_loop_bit;
    logic [15:0] r;
    logic [15:0] expCtrl;
`ifdef AUDIO_SEQ_LOOP_EN
    expCtrl = 16'h0008;
`else
    expCtrl = 16'h0000;
`endif
    hostWrite(4'd0, 16'h0008);
    hostRead(4'd0, r);
    vecs++;
    if (r !== expCtrl) begin errs++; $display("FAIL loop_bit_read: got %h required %h", r, expCtrl); end
    hostWrite(4'd0, 16'h0000);
  endtask

`ifdef AUDIO_SEQ_LOOP_EN
  task automatic test_loop;
    logic [15:0] r;
    logic [15:0] freqs [$];
    bit badCount = 0;
    bit done = 0;
    hostWrite(4'd0, 16'h0008);
    hostWrite(4'd3, 16'h0011);
    hostWrite(4'd2, 16'h0500);
    hostWrite(4'd4, 16'h0001);
    hostWrite(4'd2, 16'h0600);
    hostWrite(4'd4, 16'h0001);
    logW.delete(); logC.delete();
    hostWrite(4'd0, 16'h0009);
    Addr = 4'd1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      #1;
      if (DataRd[4:0] < 5'd1 || DataRd[4:0] > 5'd2) badCount = 1;
      freqs.delete();
      foreach (logW[k]) if (logW[k][19:16] == 4'd2) freqs.push_back(logW[k][15:0]);
      if (freqs.size() >= 4) begin done = 1; break; end
    end
    vecs++;
    if (!done) begin
      errs++; $display("FAIL loop_timeout: got %0d freq writes required 4", freqs.size());
    end else begin
      vecs++;
      if (freqs[0] !== 16'h0500 || freqs[1] !== 16'h0600 || freqs[2] !== 16'h0500 || freqs[3] !== 16'h0600) begin
        errs++; $display("FAIL loop_order: got %h %h %h %h required 0500 0600 0500 0600",
                         freqs[0], freqs[1], freqs[2], freqs[3]);
      end
    end
    vecs++;
    if (badCount) begin errs++; $display("FAIL loop_count_range: count left 1..2 required 1..2"); end
    hostWrite(4'd0, 16'h0008);
    waitIdle("loop");
    vecs++;
    if (logW.size() == 0 || logW[logW.size() - 1] !== 20'h0_0002) begin
      errs++; $display("FAIL loop_restore: got %h required 00002", (logW.size() == 0) ? 20'h0 : logW[logW.size() - 1]);
    end
    hostRead(4'd1, r);
    vecs++;
    if (r !== 16'h0002) begin errs++; $display("FAIL loop_count_end: got %h required 0002", r); end
    hostWrite(4'd0, 16'h0002);
  endtask
`endif

  initial begin
    test_reset;
    test_single_note;
    test_back_to_back;
    test_overflow;
    test_flush_play;
    test_run_clear;
    test_reset_mid;
    test_loop_bit;
`ifdef AUDIO_SEQ_LOOP_EN
    test_loop;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
